// File: rtl/divider_rebuild.sv
// Shift-add multiplier rebuilding dividend = quotient*divisor + remainder, LSB first.
// Latency: N+1 cycles from acceptance to the out_valid pulse; one operation per N+2 cycles.
// Backpressure: in_ready is high only in IDLE; in_valid offered while busy is ignored.
module divider_rebuild #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   quotient,
   input  logic [M-1:0]   divisor,
   input  logic [M-1:0]   remainder,
   output logic           out_valid,
   output logic [N+M-1:0] dividend,
   output logic           ovf,
   output logic           rem_err,
   output logic           div_zero
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int W  = N + M;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    acc;
   logic [W-1:0]    mcand;
   logic [N-1:0]    mplier;
   logic            rem_err_q;
   logic            div_zero_q;
   logic [W-1:0]    acc_nxt;

   // Accumulator value after this CALC step; also what DONE publishes on the last step.
   always_comb begin
      acc_nxt = acc;
      if (mplier[0])
         acc_nxt = acc + mcand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         dividend   <= '0;
         ovf        <= 1'b0;
         rem_err    <= 1'b0;
         div_zero   <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         rem_err_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc        <= {{N{1'b0}}, remainder};
                  mcand      <= {{N{1'b0}}, divisor};
                  mplier     <= quotient;
                  cnt        <= CW'(N - 1);
                  div_zero_q <= (divisor == '0);
                  rem_err_q  <= (divisor != '0) && (remainder >= divisor);
                  in_ready   <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == '0) begin
                  // Flags are published together with the result so all fields stay coherent.
                  dividend  <= acc_nxt;
                  ovf       <= |acc_nxt[W-1:N];
                  rem_err   <= rem_err_q;
                  div_zero  <= div_zero_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_divider_rebuild.sv
// Randomized and directed checks of divider_rebuild against an arithmetic reference model.
module tb_divider_rebuild;
   localparam int N = 8;
   localparam int M = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   quotient;
   logic [M-1:0]   divisor;
   logic [M-1:0]   remainder;
   logic           out_valid;
   logic [N+M-1:0] dividend;
   logic           ovf;
   logic           rem_err;
   logic           div_zero;

   int n_cmp = 0;
   int n_bad = 0;

   divider_rebuild #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .dividend  (dividend),
      .ovf       (ovf),
      .rem_err   (rem_err),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: plain arithmetic from the definition of division.
   task automatic check_result(input string tag, input int q, input int d, input int r);
      int exp_div;
      exp_div = q * d + r;
      chk({tag, "_dividend"}, 32'(dividend), 32'(exp_div));
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_div >= (1 << N)));
      chk({tag, "_rem_err"}, 32'(rem_err), 32'((d != 0) && (r >= d)));
      chk({tag, "_div_zero"}, 32'(div_zero), 32'(d == 0));
   endtask

   // Wait on negedges until out_valid; returns cycles waited (bounded).
   task automatic wait_out(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic do_op(input string tag, input int q, input int d, input int r);
      int w;
      int lat;
      logic [N+M-1:0] held;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      quotient  = N'(q);
      divisor   = M'(d);
      remainder = M'(r);
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      quotient  = N'($urandom);
      divisor   = M'($urandom);
      remainder = M'($urandom);
      @(negedge clk);
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      lat = 1;
      wait_out(w);
      lat += w;
      chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
      check_result(tag, q, d, r);
      held = dividend;
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
      chk({tag, "_hold"}, 32'(dividend), 32'(held));
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      in_valid = 1'b0;
      quotient = '0;
      divisor = '0;
      remainder = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dividend", 32'(dividend), 32'd0);
      chk("rst_flags", 32'({ovf, rem_err, div_zero}), 32'd0);
      rst = 1'b0;

      do_op("t1", 23, 5, 3);
      do_op("t2", 0, 9, 7);
      do_op("t3", 255, 15, 14);
      do_op("t4a", 10, 5, 5);
      do_op("t4b", 3, 0, 2);

      // Held in_valid: second operand set waits for the IDLE cycle after DONE.
      @(negedge clk);
      quotient = 8'd1; divisor = 4'd1; remainder = 4'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      quotient = 8'd2; divisor = 4'd3; remainder = 4'd1;
      @(negedge clk);
      wait_out(w);
      chk("t5_lat1", 32'(w + 1), 32'(N + 1));
      check_result("t5a", 1, 1, 0);
      @(negedge clk);
      w = 1;
      while (!out_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b0;
      chk("t5_spacing", 32'(w), 32'(N + 2));
      check_result("t5b", 2, 3, 1);

      // Reset during CALC abandons the operation.
      @(negedge clk);
      @(negedge clk);
      quotient = 8'd200; divisor = 4'd7; remainder = 4'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      chk("t6_outs", 32'({out_valid, ovf, rem_err, div_zero}), 32'd0);
      chk("t6_dividend", 32'(dividend), 32'd0);
      w = 0;
      for (int i = 0; i < N + 3; i++) begin
         @(negedge clk);
         if (out_valid) w++;
      end
      chk("t6_no_pulse", 32'(w), 32'd0);
      do_op("t6", 200, 7, 3);

      for (int i = 0; i < 60; i++)
         do_op("rnd", int'($urandom_range(0, (1 << N) - 1)),
               int'($urandom_range(0, (1 << M) - 1)),
               int'($urandom_range(0, (1 << M) - 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/divider_rebuild.md
Name: divider_rebuild

Overview:
Sequential shift-add multiplier that inverts the pipelined restoring divider. It reconstructs dividend = quotient*divisor + remainder, one quotient bit per cycle, LSB first. It sits beside the divider array as a self-check and result-recovery block. It accepts one operand set per transaction and flags results that cannot have come from a legal N-bit/M-bit division.

Parameters:
N, 8, quotient width and legal dividend width (N >= M >= 1)
M, 4, divisor and remainder width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand set offered
in_ready  output  1  block can accept operands (IDLE only)
quotient  input  N  quotient from divider
divisor  input  M  divisor
remainder  input  M  remainder from divider
out_valid  output  1  one-cycle pulse, result fields valid
dividend  output  N+M  quotient*divisor + remainder, full width
ovf  output  1  dividend[N+M-1:N] nonzero, so the result is not a legal N-bit dividend
rem_err  output  1  remainder >= divisor with divisor != 0
div_zero  output  1  divisor == 0

Behaviour:
- Reset (rst high at a clock edge, any state): state=IDLE; in_ready=1; out_valid=0; dividend=0; ovf=0; rem_err=0; div_zero=0; internal counter/acc/mcand/mplier=0. Reset mid-CALC abandons the operation with no out_valid.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid=1:
  - acc={N'b0,remainder}; mcand={N'b0,divisor}; mplier=quotient; cnt=N-1.
  - rem_err and div_zero are captured from the inputs at this edge.
  - Go to CALC. Inputs are sampled only at acceptance and may change afterwards.
- CALC, each cycle:
  - if mplier[0], acc <= acc + mcand (N+M-bit add, cannot overflow; max sum < 2^(N+M));
  - mcand <= mcand<<1; mplier <= mplier>>1;
  - if cnt==0 go to DONE, else cnt <= cnt-1. Exactly N CALC cycles.
- DONE: out_valid=1 for exactly this cycle; dividend=acc; ovf=|acc[N+M-1:N]. Next state is IDLE unconditionally.
- in_ready=0 in CALC and DONE. in_valid during those states is ignored, not queued.
- Latency: acceptance edge at cycle 0, out_valid high during cycle N+1. Throughput is one operation per N+2 cycles. A held in_valid is re-accepted on the first IDLE cycle after DONE.
- dividend, ovf, rem_err and div_zero hold their last values after DONE until the next DONE or reset. out_valid is a pulse only.
- Flag rules:
  - div_zero=1 forces rem_err=0.
  - When divisor=0, dividend is still computed (equals remainder).
  - Flags are independent; multiple flags may be set together.
- quotient=0: N CALC cycles still run, with no adds.

Test Plan:
1. Reset, then q=23, d=5, r=3 with in_valid -> in_ready drops next cycle; out_valid pulses at cycle 9; dividend=118; ovf=0; rem_err=0; div_zero=0.
2. q=0, d=9, r=7 -> dividend=7; all flags 0; latency still 9 cycles.
3. q=255, d=15, r=14 -> dividend=3839 (0xEFF); ovf=1; rem_err=0.
4. q=10, d=5, r=5 -> dividend=55; rem_err=1. Then q=3, d=0, r=2 -> dividend=2; div_zero=1; rem_err=0.
5. in_valid held high with q=1, d=1, r=0, then q=2, d=3, r=1 presented during CALC -> the second set is not accepted until IDLE after DONE. The new operands must be presented in that IDLE cycle. Results are 1, then 7, with out_valid pulses 10 cycles apart.
6. Start q=200, d=7, r=3; assert rst in CALC cycle 4 -> no out_valid; all outputs 0 the next cycle; in_ready=1. A fresh q=200, d=7, r=3 then gives dividend=1403 with ovf=1.
